// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - opcodes, control-bundle layout, forwarding codes and MDU state type
package pipe_pkg;

   localparam logic [6:0] OP_ALUR   = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // EX bundle {MulDiv,RegWrite,MemtoReg,MemRead,MemWrite,Branch,AddSrc,ALUSrc}
   localparam int C_ALUSRC   = 0;
   localparam int C_ADDSRC   = 1;
   localparam int C_BRANCH   = 2;
   localparam int C_MEMWRITE = 3;
   localparam int C_MEMREAD  = 4;
   localparam int C_MEMTOREG = 5;
   localparam int C_REGWRITE = 6;
   localparam int C_MULDIV   = 7;

   localparam int MC_REGWRITE = 3;
   localparam int WC_REGWRITE = 1;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_BUSY = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/pipe_decode.sv
// rtl/pipe_decode.sv - combinational ID decode into the control bundle and source-use flags
module pipe_decode
   import pipe_pkg::*;
(
   input  logic       valid,
   input  logic [6:0] opcode,
   input  logic       f7_0,
   output logic [7:0] ctrl,
   output logic       rs1_used,
   output logic       rs2_used
);

   always_comb begin
      ctrl     = '0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      if (valid) begin
         case (opcode)
            OP_ALUR: begin
               ctrl[C_REGWRITE] = 1'b1;
               ctrl[C_MULDIV]   = f7_0;
               rs1_used = 1'b1;
               rs2_used = 1'b1;
            end
            OP_ALUI: begin
               ctrl[C_REGWRITE] = 1'b1;
               ctrl[C_ALUSRC]   = 1'b1;
               rs1_used = 1'b1;
            end
            OP_LOAD: begin
               ctrl[C_REGWRITE] = 1'b1;
               ctrl[C_MEMTOREG] = 1'b1;
               ctrl[C_MEMREAD]  = 1'b1;
               ctrl[C_ALUSRC]   = 1'b1;
               rs1_used = 1'b1;
            end
            OP_STORE: begin
               ctrl[C_MEMWRITE] = 1'b1;
               ctrl[C_ALUSRC]   = 1'b1;
               rs1_used = 1'b1;
               rs2_used = 1'b1;
            end
            OP_BRANCH: begin
               ctrl[C_BRANCH] = 1'b1;
               rs1_used = 1'b1;
               rs2_used = 1'b1;
            end
            OP_JAL: begin
               ctrl[C_REGWRITE] = 1'b1;
               ctrl[C_BRANCH]   = 1'b1;
            end
            OP_JALR: begin
               ctrl[C_REGWRITE] = 1'b1;
               ctrl[C_BRANCH]   = 1'b1;
               ctrl[C_ADDSRC]   = 1'b1;
               ctrl[C_ALUSRC]   = 1'b1;
               rs1_used = 1'b1;
            end
            OP_LUI: begin
               ctrl[C_REGWRITE] = 1'b1;
               ctrl[C_ALUSRC]   = 1'b1;
            end
            OP_AUIPC: begin
               ctrl[C_REGWRITE] = 1'b1;
               ctrl[C_ALUSRC]   = 1'b1;
               ctrl[C_ADDSRC]   = 1'b1;
            end
            OP_SYSTEM: rs1_used = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// rtl/pipe_ctrl_hazard.sv - staged control bundle with load-use/RAW stall, flush, forwarding and MDU hold
module pipe_ctrl_hazard
   import pipe_pkg::*;
#(
   parameter int RA_W       = 5,
   parameter int MDU_CYCLES = 8,
   parameter bit EN_FWD     = 1'b1
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [6:0]      id_opcode,
   input  logic            id_f7_0,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic [RA_W-1:0] id_rd,
   input  logic            ex_taken,
   output logic            stall_f,
   output logic            flush_d,
   output logic [7:0]      ex_ctrl,
   output logic [3:0]      mem_ctrl,
   output logic [1:0]      wb_ctrl,
   output logic [RA_W-1:0] wb_rd,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b
);

   localparam int CNT_W = $clog2(MDU_CYCLES);

   logic [7:0]      id_ctrl;
   logic            id_use1, id_use2;
   logic [RA_W-1:0] id_rs1_u, id_rs2_u;
   logic [RA_W-1:0] ex_rd, ex_rs1, ex_rs2, mem_rd;
   logic            hz_stall, mdu_busy, mdu_start;
   mdu_state_t      mdu_state, mdu_next;
   logic [CNT_W-1:0] cnt, cnt_next;

   pipe_decode u_decode (
      .valid    (id_valid),
      .opcode   (id_opcode),
      .f7_0     (id_f7_0),
      .ctrl     (id_ctrl),
      .rs1_used (id_use1),
      .rs2_used (id_use2)
   );

   // Unused sources collapse to x0 so they can never match a producer.
   assign id_rs1_u = id_use1 ? id_rs1 : '0;
   assign id_rs2_u = id_use2 ? id_rs2 : '0;

   function automatic logic hit(input logic wr, input logic [RA_W-1:0] rd,
                                input logic [RA_W-1:0] rs);
      return wr && (rd != '0) && (rd == rs);
   endfunction

   always_comb begin
      hz_stall = 1'b0;
      if (EN_FWD)
         hz_stall = hit(ex_ctrl[C_MEMREAD], ex_rd, id_rs1_u) |
                    hit(ex_ctrl[C_MEMREAD], ex_rd, id_rs2_u);
      else
         hz_stall = hit(ex_ctrl[C_REGWRITE], ex_rd, id_rs1_u) |
                    hit(ex_ctrl[C_REGWRITE], ex_rd, id_rs2_u) |
                    hit(mem_ctrl[MC_REGWRITE], mem_rd, id_rs1_u) |
                    hit(mem_ctrl[MC_REGWRITE], mem_rd, id_rs2_u);
   end

   assign mdu_busy = (mdu_state == MDU_BUSY);
   assign stall_f  = !rst && !ex_taken && (mdu_busy || hz_stall);
   assign flush_d  = !rst && ex_taken;

   always_comb begin
      mdu_next  = mdu_state;
      cnt_next  = cnt;
      mdu_start = 1'b0;
      case (mdu_state)
         MDU_BUSY: begin
            cnt_next = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
               mdu_next = MDU_DONE;
         end
         default: begin
            mdu_start = !ex_taken && !hz_stall && id_ctrl[C_MULDIV];
            mdu_next  = mdu_start ? MDU_BUSY : MDU_IDLE;
            cnt_next  = mdu_start ? CNT_W'(MDU_CYCLES - 1) : '0;
         end
      endcase
      if (ex_taken) begin
         mdu_next = MDU_IDLE;
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mdu_state <= MDU_IDLE;
         cnt       <= '0;
      end else begin
         mdu_state <= mdu_next;
         cnt       <= cnt_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_ctrl  <= '0;
         ex_rd    <= '0;
         ex_rs1   <= '0;
         ex_rs2   <= '0;
         mem_ctrl <= '0;
         mem_rd   <= '0;
         wb_ctrl  <= '0;
         wb_rd    <= '0;
      end else begin
         wb_ctrl <= mem_ctrl[3:2];
         wb_rd   <= mem_rd;
         if (!ex_taken && mdu_busy) begin
            mem_ctrl <= '0;
            mem_rd   <= '0;
         end else begin
            mem_ctrl <= ex_ctrl[C_REGWRITE:C_MEMWRITE];
            mem_rd   <= ex_rd;
            if (ex_taken || hz_stall) begin
               ex_ctrl <= '0;
               ex_rd   <= '0;
               ex_rs1  <= '0;
               ex_rs2  <= '0;
            end else begin
               ex_ctrl <= id_ctrl;
               ex_rd   <= id_valid ? id_rd : '0;
               ex_rs1  <= id_rs1_u;
               ex_rs2  <= id_rs2_u;
            end
         end
      end
   end

   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (EN_FWD && !rst) begin
         if (hit(mem_ctrl[MC_REGWRITE], mem_rd, ex_rs1))     fwd_a = FWD_EXMEM;
         else if (hit(wb_ctrl[WC_REGWRITE], wb_rd, ex_rs1))  fwd_a = FWD_MEMWB;
         if (hit(mem_ctrl[MC_REGWRITE], mem_rd, ex_rs2))     fwd_b = FWD_EXMEM;
         else if (hit(wb_ctrl[WC_REGWRITE], wb_rd, ex_rs2))  fwd_b = FWD_MEMWB;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// tb/tb_pipe_ctrl_hazard.sv - directed and random checks of both forwarding configurations against an instruction-level model
module tb_pipe_ctrl_hazard;

   localparam int MDU = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [6:0] id_opcode = '0;
   logic       id_f7_0 = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic       ex_taken = 1'b0;

   logic [1:0] o_stall, o_flush;
   logic [7:0] o_ex   [2];
   logic [3:0] o_mem  [2];
   logic [1:0] o_wb   [2];
   logic [4:0] o_wbrd [2];
   logic [1:0] o_fa   [2];
   logic [1:0] o_fb   [2];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   pipe_ctrl_hazard #(.RA_W(5), .MDU_CYCLES(MDU), .EN_FWD(1'b1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_f7_0(id_f7_0),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
      .stall_f(o_stall[1]), .flush_d(o_flush[1]), .ex_ctrl(o_ex[1]), .mem_ctrl(o_mem[1]),
      .wb_ctrl(o_wb[1]), .wb_rd(o_wbrd[1]), .fwd_a(o_fa[1]), .fwd_b(o_fb[1]));

   pipe_ctrl_hazard #(.RA_W(5), .MDU_CYCLES(MDU), .EN_FWD(1'b0)) dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_f7_0(id_f7_0),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
      .stall_f(o_stall[0]), .flush_d(o_flush[0]), .ex_ctrl(o_ex[0]), .mem_ctrl(o_mem[0]),
      .wb_ctrl(o_wb[0]), .wb_rd(o_wbrd[0]), .fwd_a(o_fa[0]), .fwd_b(o_fb[0]));

   // Instruction record: what it does and which registers it really reads (0 = none).
   typedef struct packed {
      logic md, rw, m2r, mr, mw, br, adds, alus;
      logic [4:0] rd, rs1, rs2;
   } ins_t;

   ins_t m_ex [2];
   ins_t m_mem[2];
   ins_t m_wb [2];
   int   occ  [2];   // cycles the MUL/DIV in EX still occupies EX, including this one

   function automatic ins_t mdec(input logic v, input logic [6:0] op, input logic f7,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      ins_t i = '0;
      if (!v) return i;
      i.rd = rd;
      case (op)
         7'h33: begin i.rw = 1; i.md = f7; i.rs1 = r1; i.rs2 = r2; end
         7'h13: begin i.rw = 1; i.alus = 1; i.rs1 = r1; end
         7'h03: begin i.rw = 1; i.m2r = 1; i.mr = 1; i.alus = 1; i.rs1 = r1; end
         7'h23: begin i.mw = 1; i.alus = 1; i.rs1 = r1; i.rs2 = r2; end
         7'h63: begin i.br = 1; i.rs1 = r1; i.rs2 = r2; end
         7'h6f: begin i.rw = 1; i.br = 1; end
         7'h67: begin i.rw = 1; i.br = 1; i.adds = 1; i.alus = 1; i.rs1 = r1; end
         7'h37: begin i.rw = 1; i.alus = 1; end
         7'h17: begin i.rw = 1; i.alus = 1; i.adds = 1; end
         7'h73: i.rs1 = r1;
         default: ;
      endcase
      return i;
   endfunction

   function automatic logic reads(input ins_t i, input logic [4:0] r);
      return (r != 0) && ((i.rs1 == r) || (i.rs2 == r));
   endfunction

   function automatic logic must_wait(input int c, input ins_t id);
      if (c == 1) return m_ex[c].mr && reads(id, m_ex[c].rd);
      return (m_ex[c].rw && reads(id, m_ex[c].rd)) || (m_mem[c].rw && reads(id, m_mem[c].rd));
   endfunction

   function automatic logic [1:0] src_sel(input int c, input logic [4:0] rs);
      if (c == 0 || rs == 0) return 2'b00;
      if (m_mem[c].rw && m_mem[c].rd == rs) return 2'b10;
      if (m_wb[c].rw && m_wb[c].rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_ex[c] = '0; m_mem[c] = '0; m_wb[c] = '0; occ[c] = 0;
      end
   endtask

   task automatic check_model();
      ins_t id = mdec(id_valid, id_opcode, id_f7_0, id_rs1, id_rs2, id_rd);
      for (int c = 0; c < 2; c++) begin
         logic st = !ex_taken && (occ[c] > 1 || must_wait(c, id));
         chk($sformatf("c%0d stall_f", c), 32'(o_stall[c]), 32'(st));
         chk($sformatf("c%0d flush_d", c), 32'(o_flush[c]), 32'(ex_taken));
         chk($sformatf("c%0d ex_ctrl", c), 32'(o_ex[c]),
             32'({m_ex[c].md, m_ex[c].rw, m_ex[c].m2r, m_ex[c].mr, m_ex[c].mw,
                  m_ex[c].br, m_ex[c].adds, m_ex[c].alus}));
         chk($sformatf("c%0d mem_ctrl", c), 32'(o_mem[c]),
             32'({m_mem[c].rw, m_mem[c].m2r, m_mem[c].mr, m_mem[c].mw}));
         chk($sformatf("c%0d wb_ctrl", c), 32'(o_wb[c]), 32'({m_wb[c].rw, m_wb[c].m2r}));
         chk($sformatf("c%0d wb_rd", c), 32'(o_wbrd[c]), 32'(m_wb[c].rd));
         chk($sformatf("c%0d fwd_a", c), 32'(o_fa[c]), 32'(src_sel(c, m_ex[c].rs1)));
         chk($sformatf("c%0d fwd_b", c), 32'(o_fb[c]), 32'(src_sel(c, m_ex[c].rs2)));
      end
   endtask

   task automatic advance();
      ins_t id = mdec(id_valid, id_opcode, id_f7_0, id_rs1, id_rs2, id_rd);
      for (int c = 0; c < 2; c++) begin
         m_wb[c] = m_mem[c];
         if (ex_taken) begin
            m_mem[c] = m_ex[c]; m_ex[c] = '0; occ[c] = 0;
         end else if (occ[c] > 1) begin
            m_mem[c] = '0; occ[c]--;
         end else if (must_wait(c, id)) begin
            m_mem[c] = m_ex[c]; m_ex[c] = '0; occ[c] = 0;
         end else begin
            m_mem[c] = m_ex[c]; m_ex[c] = id; occ[c] = id.md ? MDU : 0;
         end
      end
   endtask

   task automatic step(input logic v, input logic [6:0] op, input logic f7, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic tk);
      @(negedge clk);
      id_valid = v; id_opcode = op; id_f7_0 = f7;
      id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_taken = tk;
      #2;
      check_model();
      advance();
   endtask

   task automatic nop();
      step(1'b0, 7'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) nop();
   endtask

   task automatic check_zero(input string tag);
      for (int c = 0; c < 2; c++) begin
         chk($sformatf("%s c%0d outputs", tag, c),
             {o_ex[c], o_mem[c], o_wb[c], o_wbrd[c], o_fa[c], o_fb[c], o_stall[c], o_flush[c]}, 32'd0);
      end
   endtask

   logic [6:0] ops [11];
   int stalls;

   initial begin
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73, 7'h7f};
      model_reset();
      #12;
      check_zero("reset");
      @(negedge clk) rst = 1'b0;

      // mul held in EX, reset asserted mid-hold while counter would be 3
      drain();
      step(1'b1, 7'h33, 1'b1, 5'd1, 5'd2, 5'd10, 1'b0);
      for (int k = 1; k <= 5; k++) nop();
      #1 rst = 1'b1;
      #1 check_zero("rst mid-busy");
      model_reset();
      id_valid = 1'b0; ex_taken = 1'b0;
      @(negedge clk) rst = 1'b0;
      step(1'b1, 7'h33, 1'b1, 5'd1, 5'd2, 5'd10, 1'b0);
      stalls = 0;
      for (int k = 1; k <= 10; k++) begin
         nop();
         stalls += int'(o_stall[1]);
      end
      chk("mdu stall count after reset", 32'(stalls), 32'(MDU - 1));

      // load-use then MEM/WB forward
      drain();
      step(1'b1, 7'h03, 1'b0, 5'd2, 5'd0, 5'd5, 1'b0);
      step(1'b1, 7'h33, 1'b0, 5'd5, 5'd1, 5'd6, 1'b0);
      chk("load-use stall", 32'(o_stall[1]), 32'd1);
      step(1'b1, 7'h33, 1'b0, 5'd5, 5'd1, 5'd6, 1'b0);
      chk("load-use released", 32'(o_stall[1]), 32'd0);
      chk("load-use ex bubble", 32'(o_ex[1]), 32'd0);
      nop();
      chk("load-use fwd_a", 32'(o_fa[1]), 32'b01);
      chk("load-use fwd_b", 32'(o_fb[1]), 32'b00);

      // ALU RAW: forwarded with EN_FWD=1, two stall cycles without
      drain();
      step(1'b1, 7'h33, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
      step(1'b1, 7'h33, 1'b0, 5'd3, 5'd3, 5'd4, 1'b0);
      chk("raw fwd no stall", 32'(o_stall[1]), 32'd0);
      chk("raw nofwd stall 1", 32'(o_stall[0]), 32'd1);
      step(1'b1, 7'h33, 1'b0, 5'd3, 5'd3, 5'd4, 1'b0);
      chk("raw fwd_a exmem", 32'(o_fa[1]), 32'b10);
      chk("raw fwd_b exmem", 32'(o_fb[1]), 32'b10);
      chk("raw nofwd stall 2", 32'(o_stall[0]), 32'd1);
      chk("raw nofwd fwd_a", 32'(o_fa[0]), 32'b00);
      step(1'b1, 7'h33, 1'b0, 5'd3, 5'd3, 5'd4, 1'b0);
      chk("raw nofwd clear", 32'(o_stall[0]), 32'd0);

      // mul then add
      drain();
      step(1'b1, 7'h33, 1'b1, 5'd1, 5'd2, 5'd10, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 7'h33, 1'b0, 5'd3, 5'd4, 5'd11, 1'b0);
         chk($sformatf("mul stall k=%0d", k), 32'(o_stall[1]), 32'(k <= MDU - 1));
         if (k >= 2 && k <= MDU) chk($sformatf("mul mem bubble k=%0d", k), 32'(o_mem[1]), 32'd0);
         if (k == MDU + 1) chk("mul in mem", 32'(o_mem[1]), 32'b1000);
         if (k == MDU + 2) begin
            chk("mul in wb", 32'(o_wb[1]), 32'b10);
            chk("mul wb_rd", 32'(o_wbrd[1]), 32'd10);
         end
      end

      // taken branch beats a pending load-use
      drain();
      step(1'b1, 7'h03, 1'b0, 5'd1, 5'd0, 5'd7, 1'b0);
      step(1'b1, 7'h33, 1'b0, 5'd7, 5'd7, 5'd8, 1'b1);
      chk("flush flush_d", 32'(o_flush[1]), 32'd1);
      chk("flush stall_f", 32'(o_stall[1]), 32'd0);
      chk("flush nofwd stall_f", 32'(o_stall[0]), 32'd0);
      nop();
      chk("flush ex bubble", 32'(o_ex[1]), 32'd0);
      chk("flush fwd_a", 32'(o_fa[1]), 32'b00);

      // x0 never hazards; jal writes back after 3 cycles
      drain();
      step(1'b1, 7'h33, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0);
      step(1'b1, 7'h03, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("x0 nofwd stall", 32'(o_stall[0]), 32'd0);
      step(1'b1, 7'h33, 1'b0, 5'd0, 5'd0, 5'd9, 1'b0);
      chk("x0 load-use stall", 32'(o_stall[1]), 32'd0);
      nop();
      chk("x0 fwd", 32'({o_fa[1], o_fb[1]}), 32'd0);
      step(1'b1, 7'h6f, 1'b0, 5'd0, 5'd0, 5'd1, 1'b0);
      for (int k = 0; k < 3; k++) nop();
      chk("jal wb_ctrl", 32'(o_wb[1]), 32'b10);
      chk("jal wb_rd", 32'(o_wbrd[1]), 32'd1);

      // random traffic over a small register set
      for (int n = 0; n < 400; n++) begin
         logic tk;
         tk = ($urandom_range(0, 7) == 0) && occ[0] <= 1 && occ[1] <= 1;
         step($urandom_range(0, 7) != 0, ops[$urandom_range(0, 10)], $urandom_range(0, 3) == 0,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), tk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
